// File: rtl/rv32i_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_fetch_pkg
// Brief   : Shared types, constants and sizing helpers for the RV32I fetch stage
// Revision: 1.0
// ============================================================================
package rv32i_fetch_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOAD    = 2'd1,
    RESTART = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  function automatic int ADDR_W(input int DEPTH);
    return (DEPTH > 1) ? $clog2(DEPTH) : 1;
  endfunction

  // One extra bit so a completely full queue is representable.
  function automatic int CNT_W(input int DEPTH);
    return $clog2(DEPTH) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_fetch_queue
// Brief   : Synchronous FIFO of fetch entries with flush; head is registered storage
// Revision: 1.0
// ============================================================================
module rv32i_fetch_queue
  import rv32i_fetch_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  fetch_entry_t                  i_entry,
  input  logic                          i_pop,
  input  logic                          i_flush,
  output fetch_entry_t                  o_head,
  output logic [CNT_W(QUEUE_DEPTH)-1:0] o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int PTR_W    = ADDR_W(QUEUE_DEPTH);
  localparam int CNT_BITS = CNT_W(QUEUE_DEPTH);

  fetch_entry_t        r_slots [QUEUE_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_count   = r_count;
  assign o_full    = (r_count == CNT_BITS'(QUEUE_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so push at full is legal then.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_slots[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_BITS'(w_do_push) - CNT_BITS'(w_do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_slots[r_wr_ptr] <= i_entry;
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full && !w_do_pop && !i_flush));

endmodule
`default_nettype wire

// File: rtl/rv32i_prefetch_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_prefetch_fetch_stage
// Brief   : RV32I fetch with instruction memory, loader port and prefetch queue
// Revision: 1.0
// ============================================================================
module rv32i_prefetch_fetch_stage
  import rv32i_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH  = 512,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_miss,
  input  logic [31:0] i_branch_pc,
  input  logic        i_decode_ready,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_instruction,
  output logic [31:0] o_fetch_instruction_pc,
  output logic        o_fetch_fault,
  output logic        o_instruction_latch_en,
  input  logic        i_instruction_wr_en,
  input  logic [31:0] i_instruction_wr_addr,
  input  logic [31:0] i_instruction_wr_data,
  output logic        o_instruction_wr_valid
);

  localparam int MEM_AW   = ADDR_W(IMEM_DEPTH);
  localparam int CNT_BITS = CNT_W(QUEUE_DEPTH);
  localparam int OCC_W    = CNT_BITS + 1;

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [31:0]         r_pc;
  logic                r_issue_hold;
  logic                r_inflight;
  logic [31:0]         r_rsp_pc;
  logic                r_rsp_fault;
  logic [31:0]         r_rdata;
  logic                r_wr_valid;
  logic [31:0]         r_imem [IMEM_DEPTH];

  logic                w_run;
  logic                w_restart;
  logic                w_redirect;
  logic                w_flush;
  logic                w_pop;
  logic                w_issue;
  logic                w_wr_accept;
  logic                w_room;
  logic [OCC_W-1:0]    w_occupancy;
  fetch_entry_t        w_push_entry;
  fetch_entry_t        w_head;
  logic [CNT_BITS-1:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_unused_bits;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (i_instruction_wr_en) w_state_next = LOAD;
      LOAD:    if (!i_instruction_wr_en && !r_wr_valid) w_state_next = RESTART;
      RESTART: w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_run       = (r_state == RUN);
    w_restart   = (r_state == RESTART);
    w_wr_accept = (r_state == LOAD) && i_instruction_wr_en && !r_wr_valid;
    w_redirect  = w_run && i_branch_miss;
    w_flush     = !w_run || i_branch_miss || i_instruction_wr_en;
    w_pop       = !w_empty && i_decode_ready;
    // Reserve a slot for the read already in flight before issuing another.
    w_occupancy = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    w_room      = (w_occupancy < OCC_W'(QUEUE_DEPTH));
    w_issue     = w_run && !i_instruction_wr_en && !i_branch_miss && !r_issue_hold && w_room;
  end

  // The hold bubble after reset/redirect/restart aligns all restarts to a 3-edge latency.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_issue_hold <= 1'b1;
      r_inflight   <= 1'b0;
      r_rsp_pc     <= '0;
      r_rsp_fault  <= 1'b0;
      r_wr_valid   <= 1'b0;
    end else begin
      r_wr_valid   <= w_wr_accept;
      r_inflight   <= w_issue;
      r_issue_hold <= w_restart || w_redirect;
      if (w_restart)       r_pc <= RESET_PC;
      else if (w_redirect) r_pc <= {i_branch_pc[31:2], 2'b00};
      else if (w_issue)    r_pc <= r_pc + 32'd4;
      if (w_issue) begin
        r_rsp_pc    <= r_pc;
        r_rsp_fault <= (r_pc[31:2] >= 30'(IMEM_DEPTH));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_accept && (i_instruction_wr_addr < 32'(IMEM_DEPTH)))
      r_imem[i_instruction_wr_addr[MEM_AW-1:0]] <= i_instruction_wr_data;
    r_rdata <= r_imem[r_pc[MEM_AW+1:2]];
  end

  always_comb begin
    w_push_entry.instr = r_rsp_fault ? RV32I_NOP : r_rdata;
    w_push_entry.pc    = r_rsp_pc;
    w_push_entry.fault = r_rsp_fault;
  end

  rv32i_fetch_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (r_inflight),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_fetch_valid          = !w_empty;
  assign o_fetch_instruction    = w_empty ? 32'h0 : w_head.instr;
  assign o_fetch_instruction_pc = w_empty ? 32'h0 : w_head.pc;
  assign o_fetch_fault          = !w_empty && w_head.fault;
  assign o_instruction_latch_en = w_pop;
  assign o_instruction_wr_valid = r_wr_valid;
  assign w_unused_bits          = ^{i_branch_pc[1:0], w_full};

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prefetch_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32i_prefetch_fetch_stage
// Brief   : Scoreboard bench for the prefetching RV32I fetch stage
// Revision: 1.0
// ============================================================================
module tb_rv32i_prefetch_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_branch_miss;
  logic [31:0] i_branch_pc;
  logic        i_decode_ready;
  logic        o_fetch_valid;
  logic [31:0] o_fetch_instruction;
  logic [31:0] o_fetch_instruction_pc;
  logic        o_fetch_fault;
  logic        o_instruction_latch_en;
  logic        i_instruction_wr_en;
  logic [31:0] i_instruction_wr_addr;
  logic [31:0] i_instruction_wr_data;
  logic        o_instruction_wr_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  rv32i_prefetch_fetch_stage #(
    .IMEM_DEPTH (512),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .i_clk                  (i_clk),
    .i_rst_n                (i_rst_n),
    .i_branch_miss          (i_branch_miss),
    .i_branch_pc            (i_branch_pc),
    .i_decode_ready         (i_decode_ready),
    .o_fetch_valid          (o_fetch_valid),
    .o_fetch_instruction    (o_fetch_instruction),
    .o_fetch_instruction_pc (o_fetch_instruction_pc),
    .o_fetch_fault          (o_fetch_fault),
    .o_instruction_latch_en (o_instruction_latch_en),
    .i_instruction_wr_en    (i_instruction_wr_en),
    .i_instruction_wr_addr  (i_instruction_wr_addr),
    .i_instruction_wr_data  (i_instruction_wr_data),
    .o_instruction_wr_valid (o_instruction_wr_valid)
  );

  task automatic test_reset();
    i_rst_n = 1'b0; i_branch_miss = 1'b0; i_branch_pc = '0; i_decode_ready = 1'b0;
    i_instruction_wr_en = 1'b0; i_instruction_wr_addr = '0; i_instruction_wr_data = '0;
    repeat (3) @(negedge i_clk);
    checks++; if (o_fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_fetch_valid); end
    checks++; if (o_fetch_instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", o_fetch_instruction); end
    checks++; if (o_fetch_instruction_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", o_fetch_instruction_pc); end
    checks++; if (o_fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", o_fetch_fault); end
    checks++; if (o_instruction_latch_en !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b exp=0", o_instruction_latch_en); end
    checks++; if (o_instruction_wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", o_instruction_wr_valid); end
    @(posedge i_clk); #1 i_rst_n = 1'b1;
  endtask

  // Words 0..15 hold their own index; the final write targets 515 and must be dropped.
  task automatic test_load();
    int  acks = 0;
    bit  seen;
    i_decode_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      i_instruction_wr_en   = 1'b1;
      i_instruction_wr_addr = (i == 16) ? 32'd515 : 32'(i);
      i_instruction_wr_data = (i == 16) ? 32'hDEAD_BEEF : 32'(i);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge i_clk);
        seen = o_instruction_wr_valid;
      end
      if (seen) acks++;
      else begin checks++; failures++; $display("FAIL load_ack_timeout write=%0d got=0 exp=1", i); end
      @(posedge i_clk); #1;
      if (i == 16) i_instruction_wr_en = 1'b0;
      @(negedge i_clk);
      checks++; if (o_instruction_wr_valid !== 1'b0) begin failures++; $display("FAIL load_ack_width write=%0d got=%b exp=0", i, o_instruction_wr_valid); end
    end
    checks++; if (acks != 17) begin failures++; $display("FAIL load_ack_count got=%0d exp=17", acks); end
  endtask

  task automatic test_stream();
    int   first = -1, got = 0, gaps = 0;
    exp_t e;
    for (int i = 0; i < 16; i++) exp_q.push_back('{instr: 32'(i), pc: 32'(i * 4), fault: 1'b0});
    for (int c = 1; c <= 40 && got < 16; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault || o_instruction_latch_en !== 1'b1) begin
          failures++; $display("FAIL stream_entry got pc=%h instr=%h fault=%b exp pc=%h instr=%h fault=%b", o_fetch_instruction_pc, o_fetch_instruction, o_fetch_fault, e.pc, e.instr, e.fault);
        end
        got++;
      end else if (first >= 0) gaps++;
    end
    checks++; if (got != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", got); end
    checks++; if (first != 5) begin failures++; $display("FAIL stream_latency got=%0d exp=5", first); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL stream_gaps got=%0d exp=0", gaps); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    int   got = 0, gaps = 0;
    exp_t e;
    @(posedge i_clk); #1 i_decode_ready = 1'b0; i_branch_miss = 1'b1; i_branch_pc = 32'h0;
    @(posedge i_clk); #1 i_branch_miss = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      checks++;
      if (c < 4) begin
        if (o_fetch_valid !== 1'b0) begin failures++; $display("FAIL bp_flush cycle=%0d got=%b exp=0", c, o_fetch_valid); end
      end else if (o_fetch_valid !== 1'b1 || o_fetch_instruction_pc !== 32'h0 || o_fetch_instruction !== 32'h0 || o_instruction_latch_en !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle=%0d got v=%b pc=%h instr=%h exp v=1 pc=0 instr=0", c, o_fetch_valid, o_fetch_instruction_pc, o_fetch_instruction);
      end
    end
    for (int i = 0; i < 12; i++) exp_q.push_back('{instr: 32'(i), pc: 32'(i * 4), fault: 1'b0});
    @(posedge i_clk); #1 i_decode_ready = 1'b1;
    for (int c = 1; c <= 30 && got < 12; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault) begin
          failures++; $display("FAIL bp_entry got pc=%h instr=%h exp pc=%h instr=%h", o_fetch_instruction_pc, o_fetch_instruction, e.pc, e.instr);
        end
        got++;
      end else gaps++;
    end
    checks++; if (got != 12 || gaps != 0) begin failures++; $display("FAIL bp_drain got=%0d gaps=%0d exp=12 gaps=0", got, gaps); end
    exp_q.delete();
  endtask

  task automatic test_branch_flush();
    int   got = 0, gaps = 0;
    exp_t e;
    @(posedge i_clk); #1 i_decode_ready = 1'b0;
    repeat (8) @(negedge i_clk);
    @(posedge i_clk); #1 i_branch_miss = 1'b1; i_branch_pc = 32'h0000_0011;
    for (int i = 4; i < 16; i++) exp_q.push_back('{instr: 32'(i), pc: 32'(i * 4), fault: 1'b0});
    @(posedge i_clk); #1 i_branch_miss = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge i_clk);
      checks++;
      if (c < 4 && o_fetch_valid !== 1'b0) begin
        failures++; $display("FAIL br_flush cycle=%0d got=%b exp=0", c, o_fetch_valid);
      end else if (c == 4 && (o_fetch_valid !== 1'b1 || o_fetch_instruction_pc !== 32'h10 || o_fetch_instruction !== 32'h4)) begin
        failures++; $display("FAIL br_target got v=%b pc=%h instr=%h exp v=1 pc=10 instr=4", o_fetch_valid, o_fetch_instruction_pc, o_fetch_instruction);
      end
    end
    @(posedge i_clk); #1 i_decode_ready = 1'b1;
    for (int c = 1; c <= 30 && got < 12; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault) begin
          failures++; $display("FAIL br_entry got pc=%h instr=%h exp pc=%h instr=%h", o_fetch_instruction_pc, o_fetch_instruction, e.pc, e.instr);
        end
        got++;
      end else gaps++;
    end
    checks++; if (got != 12 || gaps != 0) begin failures++; $display("FAIL br_drain got=%0d gaps=%0d exp=12 gaps=0", got, gaps); end
    exp_q.delete();
  endtask

  task automatic test_out_of_range();
    int   first = -1, got = 0;
    exp_t e;
    @(posedge i_clk); #1 i_branch_miss = 1'b1; i_branch_pc = 32'h0000_0800;
    for (int i = 0; i < 3; i++) exp_q.push_back('{instr: 32'h0000_0013, pc: 32'h800 + 32'(i * 4), fault: 1'b1});
    @(posedge i_clk); #1 i_branch_miss = 1'b0;
    for (int c = 1; c <= 20 && got < 3; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault) begin
          failures++; $display("FAIL oor_entry got pc=%h instr=%h fault=%b exp pc=%h instr=%h fault=%b", o_fetch_instruction_pc, o_fetch_instruction, o_fetch_fault, e.pc, e.instr, e.fault);
        end
        got++;
      end
    end
    checks++; if (got != 3 || first != 4) begin failures++; $display("FAIL oor_latency got count=%0d first=%0d exp count=3 first=4", got, first); end
    exp_q.delete();
  endtask

  task automatic test_branch_pop_full();
    int   first = -1, got = 0;
    exp_t e;
    @(posedge i_clk); #1 i_decode_ready = 1'b0;
    repeat (8) @(negedge i_clk);
    @(posedge i_clk); #1 i_decode_ready = 1'b1; i_branch_miss = 1'b1; i_branch_pc = 32'h0000_0020;
    for (int i = 8; i < 12; i++) exp_q.push_back('{instr: 32'(i), pc: 32'(i * 4), fault: 1'b0});
    @(negedge i_clk);
    checks++; if (o_instruction_latch_en !== 1'b1) begin failures++; $display("FAIL bpop_latch got=%b exp=1", o_instruction_latch_en); end
    @(posedge i_clk); #1 i_branch_miss = 1'b0;
    for (int c = 1; c <= 20 && got < 4; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault) begin
          failures++; $display("FAIL bpop_entry got pc=%h instr=%h exp pc=%h instr=%h", o_fetch_instruction_pc, o_fetch_instruction, e.pc, e.instr);
        end
        got++;
      end
    end
    checks++; if (got != 4 || first != 4) begin failures++; $display("FAIL bpop_latency got count=%0d first=%0d exp count=4 first=4", got, first); end
    exp_q.delete();
  endtask

  task automatic test_async_reset_mid_load();
    int   first = -1, got = 0;
    bit   seen = 1'b0;
    exp_t e;
    @(posedge i_clk); #1 i_instruction_wr_en = 1'b1; i_instruction_wr_addr = 32'd5; i_instruction_wr_data = 32'h0000_0055;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge i_clk);
      seen = o_instruction_wr_valid;
    end
    checks++; if (!seen) begin failures++; $display("FAIL arst_ack_timeout got=0 exp=1"); end
    #1 i_rst_n = 1'b0; i_instruction_wr_en = 1'b0;
    #1;
    checks++; if (o_instruction_wr_valid !== 1'b0) begin failures++; $display("FAIL arst_wr_valid got=%b exp=0", o_instruction_wr_valid); end
    checks++; if (o_fetch_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", o_fetch_valid); end
    checks++; if (o_instruction_latch_en !== 1'b0) begin failures++; $display("FAIL arst_latch got=%b exp=0", o_instruction_latch_en); end
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back('{instr: (i == 5) ? 32'h55 : 32'(i), pc: 32'(i * 4), fault: 1'b0});
    for (int c = 1; c <= 20 && got < 7; c++) begin
      @(negedge i_clk);
      if (o_fetch_valid && i_decode_ready) begin
        if (first < 0) first = c;
        e = exp_q.pop_front();
        checks++;
        if (o_fetch_instruction_pc !== e.pc || o_fetch_instruction !== e.instr || o_fetch_fault !== e.fault) begin
          failures++; $display("FAIL arst_entry got pc=%h instr=%h exp pc=%h instr=%h", o_fetch_instruction_pc, o_fetch_instruction, e.pc, e.instr);
        end
        got++;
      end
    end
    checks++; if (got != 7 || first != 4) begin failures++; $display("FAIL arst_restart got count=%0d first=%0d exp count=7 first=4", got, first); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_backpressure();
    test_branch_flush();
    test_out_of_range();
    test_branch_pop_full();
    test_async_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/rv32i_prefetch_fetch_stage.md
Name: rv32i_prefetch_fetch_stage

Overview:
Parametrised successor to the single-entry RV32I instruction fetch stage. Contains the instruction memory, a word-address loader port, a pipelined PC sequencer and a QUEUE_DEPTH-entry prefetch queue. It presents a valid/ready stream of {instruction, pc, fault} to decode. Branch redirect flushes the queue and drops any in-flight read.

Parameters:
IMEM_DEPTH, 512, instruction memory depth in 32-bit words (power of 2, >=4)
QUEUE_DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, PC after reset and after loader exit (word aligned)

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_branch_miss  in  1  redirect request, single-cycle pulse
i_branch_pc  in  32  redirect target; bits [1:0] ignored
i_decode_ready  in  1  decode can accept head entry this cycle
o_fetch_valid  out  1  queue head valid
o_fetch_instruction  out  32  head instruction
o_fetch_instruction_pc  out  32  head PC
o_fetch_fault  out  1  head PC was outside instruction memory
o_instruction_latch_en  out  1  o_fetch_valid & i_decode_ready (pop strobe)
i_instruction_wr_en  in  1  loader mode / write request
i_instruction_wr_addr  in  32  word index of the write
i_instruction_wr_data  in  32  instruction word
o_instruction_wr_valid  out  1  write acknowledge, one-cycle pulse

Behaviour:
- Reset (async assert, sync release): FSM=RUN, pc=RESET_PC, queue empty, no read in flight. All outputs 0. Memory contents are not reset.
- FSM states:
  - RUN -> LOAD when i_instruction_wr_en=1.
  - LOAD -> RESTART when wr_en=0 and no ack is pending.
  - RESTART -> RUN after 1 cycle; sets pc=RESET_PC and flushes.
- LOAD:
  - A write is accepted when wr_en=1 and o_instruction_wr_valid=0.
  - Memory updates at that edge; o_instruction_wr_valid=1 the next cycle for exactly 1 cycle. Maximum rate is 1 write per 2 cycles.
  - Addresses >= IMEM_DEPTH are dropped but still acknowledged.
  - No fetches are issued, the queue is held empty, and i_branch_miss is ignored.
- Fetch issue (RUN):
  - Read issued when count + inflight - pop < QUEUE_DEPTH. On issue, pc += 4.
  - Memory read is synchronous with 1-cycle latency; the response is pushed at the following edge.
  - DEPTH=2 sustains 1 instruction/cycle with decode always ready.
- Fault: if pc[31:2] >= IMEM_DEPTH, the entry gets fault=1 and instruction=32'h0000_0013 (NOP). Sequencing continues. pc wraps modulo 2^32.
- Latency: a redirect sampled at edge E gives the target at o_fetch_valid in the cycle after edge E+3 (3-edge redirect). The same applies to the first instruction after reset release and after RESTART.
- Branch miss:
  - Clears the queue, kills any in-flight response (its push is suppressed), and sets pc={i_branch_pc[31:2],2'b00}.
  - Takes priority over a same-cycle pop: o_instruction_latch_en still reflects valid&ready, and the consumer must discard that entry.
- Queue:
  - Output comes from the registered head; no fall-through.
  - Simultaneous push and pop at full is legal; count is unchanged.
  - Never overflows. Overflow is an assertion failure.
  - Outputs hold stable while valid and not ready.
- Reset mid-operation: an asserted i_rst_n clears everything immediately, including a pending write ack. Memory is kept.

Decomposition:
- Package rv32i_fetch_pkg holds:
  - the fetch_state_e enum (RUN, LOAD, RESTART)
  - the RV32I_NOP constant
  - fetch_entry_t struct {instr[31:0], pc[31:0], fault}
  - the ADDR_W/CNT_W helper functions
- Sub-module rv32i_fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count and full/empty, parametrised by QUEUE_DEPTH.

Test Plan:
- Load: write words 0..7 with data=index -> 8 ack pulses, each 1 cycle with at least 1 low cycle between. On wr_en drop, the stream starts at pc 0x0: instruction 0, then 1, 2, ... one per cycle.
- Backpressure (QUEUE_DEPTH=4, decode_ready=0 for 10 cycles) -> exactly 4 entries buffered (pcs 0x0,0x4,0x8,0xC), outputs stable. Releasing ready delivers them in order with no gap and no duplicate.
- Branch miss to 0x0000_0011 while queue is full -> queue flushed. The next valid head is pc 0x10 with instruction 4, 3 edges later. No stale pcs appear afterwards.
- Out-of-range: with IMEM_DEPTH=512, branch to 0x800 -> head pc 0x800, fault=1, instruction 0x0000_0013. Continues to 0x804 with fault=1.
- Simultaneous branch_miss and pop at a full queue -> queue empties, count never exceeds QUEUE_DEPTH, target appears after the redirect latency.
- Async reset asserted mid-LOAD with an ack pending -> wr_valid, fetch_valid and latch_en go 0 immediately. After release, fetch at RESET_PC returns the previously loaded word.
